// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and display-update types
//
// Purpose: constants shared with the VGA timing generator, the scheduler
// FSM state type and the packed display-state bundle handed to pixel_gen.
package vga_pkg;

   // 640x480 @ 60 Hz timing, shared with the VGA timing generator
   localparam int unsigned H_VISIBLE     = 640;
   localparam int unsigned H_FRONT_PORCH = 16;
   localparam int unsigned H_SYNC        = 96;
   localparam int unsigned H_BACK_PORCH  = 48;
   localparam int unsigned V_VISIBLE     = 480;
   localparam int unsigned V_FRONT_PORCH = 10;
   localparam int unsigned V_SYNC        = 2;
   localparam int unsigned V_BACK_PORCH  = 33;

   typedef enum logic [1:0] {
      SCAN,
      OPEN,
      COMMIT,
      DONE
   } sched_state_t;

   typedef struct packed {
      logic [7:0]  destination;
      logic [25:0] people_data;
      logic [1:0]  sim_state;
   } display_state_t;

endpackage

// File: rtl/vga_frame_scheduler_frame_ticker.sv
// rtl/vga_frame_scheduler_frame_ticker.sv - frame-rate timing services
//
// Purpose: detects entry into vertical blanking and keeps the per-frame
// counters used by pixel_gen animation.
// Ports:
//   pixel_clk, reset  clock, asynchronous active-high reset
//   in_blank          current line is a blanking line
//   commit            display update is being committed this cycle
//   vblank_start      one-cycle pulse on the first blanking-line cycle
//   frame_count       frames since reset, wraps at 256
//   blink             toggles every BLINK_FRAMES frames
//   stale_frames      frames since last commit, saturating at STALE_MAX
module frame_ticker
   import vga_pkg::*;
#(
   parameter int unsigned BLINK_FRAMES = 30,
   parameter int unsigned STALE_MAX    = 255
) (
   input  logic       pixel_clk,
   input  logic       reset,
   input  logic       in_blank,
   input  logic       commit,
   output logic       vblank_start,
   output logic [7:0] frame_count,
   output logic       blink,
   output logic [7:0] stale_frames
);

   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
   localparam logic [7:0] STALE_SAT  = 8'(STALE_MAX);

   logic       in_blank_q;
   logic [7:0] blink_cnt;

   // in_blank_q resets high so releasing reset in the middle of blanking
   // does not fake a blank entry.
   assign vblank_start = in_blank & ~in_blank_q;

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         in_blank_q   <= 1'b1;
         frame_count  <= 8'd0;
         blink        <= 1'b0;
         blink_cnt    <= 8'd0;
         stale_frames <= 8'd0;
      end else begin
         in_blank_q <= in_blank;
         if (vblank_start) begin
            frame_count <= frame_count + 8'd1;
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= 8'd0;
               blink     <= ~blink;
            end else begin
               blink_cnt <= blink_cnt + 8'd1;
            end
         end
         // commit comes from COMMIT, which always follows OPEN, so it can
         // never land on the same cycle as vblank_start.
         if (commit) begin
            stale_frames <= 8'd0;
         end else if (vblank_start && (stale_frames != STALE_SAT)) begin
            stale_frames <= stale_frames + 8'd1;
         end
      end
   end

endmodule

// File: rtl/vga_frame_scheduler.sv
// rtl/vga_frame_scheduler.sv - tear-free once-per-frame display update scheduler
//
// Purpose: accepts display-state updates from the simulation core over a
// req/ack handshake and commits at most one per frame, only inside vertical
// blanking, so pixel_gen never sees a half-updated frame.
// Ports:
//   pixel_clk, reset        clock, asynchronous active-high reset
//   vert_count              current line from the VGA timing counter
//   upd_req / upd_ack       level request held until the one-cycle ack
//   upd_destination, upd_people_data, upd_sim_state   requested state
//   disp_destination, disp_people_data, disp_sim_state committed state
//   vblank_start, frame_count, blink, stale_frames    frame timing services
module vga_frame_scheduler
   import vga_pkg::*;
#(
   parameter int unsigned V_VISIBLE    = vga_pkg::V_VISIBLE,
   parameter int unsigned BLINK_FRAMES = 30,
   parameter int unsigned STALE_MAX    = 255
) (
   input  logic        pixel_clk,
   input  logic        reset,
   input  logic [9:0]  vert_count,
   input  logic        upd_req,
   input  logic [7:0]  upd_destination,
   input  logic [25:0] upd_people_data,
   input  logic [1:0]  upd_sim_state,
   output logic        upd_ack,
   output logic [7:0]  disp_destination,
   output logic [25:0] disp_people_data,
   output logic [1:0]  disp_sim_state,
   output logic        vblank_start,
   output logic [7:0]  frame_count,
   output logic        blink,
   output logic [7:0]  stale_frames
);

   localparam logic [9:0] FIRST_BLANK_LINE = 10'(V_VISIBLE);

   sched_state_t   state_q;
   sched_state_t   state_d;
   display_state_t disp_q;
   display_state_t upd_state;
   logic           in_blank;
   logic           commit;

   assign in_blank  = (vert_count >= FIRST_BLANK_LINE);
   assign commit    = (state_q == COMMIT);
   assign upd_state = '{destination: upd_destination,
                        people_data: upd_people_data,
                        sim_state:   upd_sim_state};

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         state_q <= SCAN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SCAN: begin
            if (vblank_start) begin
               state_d = OPEN;
            end
         end
         OPEN: begin
            // leaving blank wins over a same-cycle request: window missed
            if (!in_blank) begin
               state_d = SCAN;
            end else if (upd_req) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            // The ack is already out, so the latch still happens; an abrupt
            // blank exit only skips DONE.
            state_d = in_blank ? DONE : SCAN;
         end
         DONE: begin
            if (!in_blank) begin
               state_d = SCAN;
            end
         end
         default: state_d = SCAN;
      endcase
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         disp_q <= '0;
      end else if (commit) begin
         disp_q <= upd_state;
      end
   end

   assign upd_ack          = commit;
   assign disp_destination = disp_q.destination;
   assign disp_people_data = disp_q.people_data;
   assign disp_sim_state   = disp_q.sim_state;

   frame_ticker #(
      .BLINK_FRAMES (BLINK_FRAMES),
      .STALE_MAX    (STALE_MAX)
   ) u_frame_ticker (
      .pixel_clk    (pixel_clk),
      .reset        (reset),
      .in_blank     (in_blank),
      .commit       (commit),
      .vblank_start (vblank_start),
      .frame_count  (frame_count),
      .blink        (blink),
      .stale_frames (stale_frames)
   );

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb/tb_vga_frame_scheduler.sv - scoreboard bench for vga_frame_scheduler
module tb_vga_frame_scheduler;
   import vga_pkg::*;

   localparam int BLINK_FRAMES = 30;
   localparam int STALE_MAX    = 255;

   logic        pixel_clk;
   logic        reset;
   logic [9:0]  vert_count;
   logic        upd_req;
   logic [7:0]  upd_destination;
   logic [25:0] upd_people_data;
   logic [1:0]  upd_sim_state;
   logic        upd_ack;
   logic [7:0]  disp_destination;
   logic [25:0] disp_people_data;
   logic [1:0]  disp_sim_state;
   logic        vblank_start;
   logic [7:0]  frame_count;
   logic        blink;
   logic [7:0]  stale_frames;

   vga_frame_scheduler #(
      .V_VISIBLE    (480),
      .BLINK_FRAMES (BLINK_FRAMES),
      .STALE_MAX    (STALE_MAX)
   ) dut (
      .pixel_clk        (pixel_clk),
      .reset            (reset),
      .vert_count       (vert_count),
      .upd_req          (upd_req),
      .upd_destination  (upd_destination),
      .upd_people_data  (upd_people_data),
      .upd_sim_state    (upd_sim_state),
      .upd_ack          (upd_ack),
      .disp_destination (disp_destination),
      .disp_people_data (disp_people_data),
      .disp_sim_state   (disp_sim_state),
      .vblank_start     (vblank_start),
      .frame_count      (frame_count),
      .blink            (blink),
      .stale_frames     (stale_frames)
   );

   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   int             checks = 0;
   int             failures = 0;
   display_state_t exp_q[$];
   int             ack_count;
   bit             cmp_pending;
   bit             prev_blank;
   int             exp_frame;
   int             exp_blink_cnt;
   bit             exp_blink;
   int             exp_stale;
   bit             chain_valid;
   display_state_t chain_val;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [7:0] d, input logic [25:0] p, input logic [1:0] s);
      upd_destination = d;
      upd_people_data = p;
      upd_sim_state   = s;
      upd_req         = 1'b1;
      exp_q.push_back('{destination: d, people_data: p, sim_state: s});
   endtask

   // One clock: sample at negedge, update the model, then drive after posedge.
   task automatic tick();
      bit             acked;
      bit             cur_blank;
      bit             exp_vbs;
      display_state_t e;
      acked = 1'b0;
      @(negedge pixel_clk);
      cur_blank = (vert_count >= 10'd480);
      exp_vbs   = cur_blank && !prev_blank;
      prev_blank = cur_blank;
      check_val("vblank_start", 32'(vblank_start), 32'(exp_vbs));
      if (cmp_pending) begin
         cmp_pending = 1'b0;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val("disp_destination", 32'(disp_destination), 32'(e.destination));
            check_val("disp_people_data", 32'(disp_people_data), 32'(e.people_data));
            check_val("disp_sim_state", 32'(disp_sim_state), 32'(e.sim_state));
         end
      end
      if (exp_vbs) begin
         exp_frame = (exp_frame + 1) % 256;
         if (exp_blink_cnt == BLINK_FRAMES - 1) begin
            exp_blink_cnt = 0;
            exp_blink     = ~exp_blink;
         end else begin
            exp_blink_cnt++;
         end
         if (exp_stale < STALE_MAX) exp_stale++;
      end
      if (upd_ack) begin
         ack_count++;
         acked       = 1'b1;
         cmp_pending = 1'b1;
         exp_stale   = 0;
         check_val("ack_has_request", 32'(exp_q.size() != 0), 32'd1);
         check_val("ack_in_blank", 32'(cur_blank), 32'd1);
      end
      @(posedge pixel_clk);
      #1;
      if (acked) begin
         if (chain_valid) begin
            chain_valid = 1'b0;
            issue(chain_val.destination, chain_val.people_data, chain_val.sim_state);
         end else begin
            upd_req = 1'b0;
         end
      end
   endtask

   task automatic end_checks();
      check_val("frame_count", 32'(frame_count), 32'(exp_frame));
      check_val("blink", 32'(blink), 32'(exp_blink));
      check_val("stale_frames", 32'(stale_frames), 32'(exp_stale));
   endtask

   task automatic frame(input int nvis, input int nblank);
      for (int i = 0; i < nvis; i++) begin
         vert_count = (i == nvis - 1) ? 10'd479 : 10'(i * 7);
         tick();
      end
      for (int i = 0; i < nblank; i++) begin
         vert_count = 10'(480 + i);
         tick();
      end
      end_checks();
   endtask

   task automatic do_reset(input logic [9:0] v);
      reset           = 1'b1;
      vert_count      = v;
      upd_req         = 1'b0;
      upd_destination = 8'd0;
      upd_people_data = 26'd0;
      upd_sim_state   = 2'd0;
      exp_q.delete();
      cmp_pending   = 1'b0;
      chain_valid   = 1'b0;
      exp_frame     = 0;
      exp_blink_cnt = 0;
      exp_blink     = 1'b0;
      exp_stale     = 0;
      #1;
      check_val("rst_upd_ack", 32'(upd_ack), 32'd0);
      check_val("rst_disp_destination", 32'(disp_destination), 32'd0);
      check_val("rst_disp_people_data", 32'(disp_people_data), 32'd0);
      check_val("rst_disp_sim_state", 32'(disp_sim_state), 32'd0);
      check_val("rst_vblank_start", 32'(vblank_start), 32'd0);
      check_val("rst_frame_count", 32'(frame_count), 32'd0);
      check_val("rst_blink", 32'(blink), 32'd0);
      check_val("rst_stale_frames", 32'(stale_frames), 32'd0);
      repeat (2) @(posedge pixel_clk);
      #1;
      reset      = 1'b0;
      prev_blank = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ack_count = 0;

      // reset released mid-blank: no ack until the next real blank entry
      do_reset(10'd500);
      issue(8'h3C, 26'h2AB_CDE, 2'd2);
      for (int i = 0; i < 3; i++) begin
         vert_count = 10'(501 + i);
         tick();
         check_val("t1_no_ack_blank", 32'(ack_count), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         vert_count = (i == 3) ? 10'd479 : 10'(i * 10);
         tick();
         check_val("t1_no_ack_visible", 32'(ack_count), 32'd0);
      end
      vert_count = 10'd480;
      tick();
      check_val("t1_no_ack_edge", 32'(ack_count), 32'd0);
      vert_count = 10'd481;
      tick();
      check_val("t1_no_ack_edge1", 32'(ack_count), 32'd0);
      vert_count = 10'd482;
      tick();
      check_val("t1_ack_edge2", 32'(ack_count), 32'd1);
      vert_count = 10'd483;
      tick();
      vert_count = 10'd484;
      tick();
      end_checks();

      // request during visible line 100 is withheld until blanking
      vert_count = 10'd100;
      issue(8'hA5, 26'h155_5555, 2'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val("t2_ack_withheld", 32'(ack_count), 32'd1);
         check_val("t2_disp_hold", 32'(disp_destination), 32'h3C);
      end
      frame(4, 5);
      check_val("t2_ack", 32'(ack_count), 32'd2);
      check_val("t2_disp_a5", 32'(disp_destination), 32'hA5);

      // back-to-back request right after an ack waits for the next frame
      issue(8'h5A, 26'h0F0_F0F0, 2'd3);
      chain_valid = 1'b1;
      chain_val   = '{destination: 8'hC3, people_data: 26'h3FF_0001, sim_state: 2'd0};
      frame(4, 5);
      check_val("t3_one_ack_frame", 32'(ack_count), 32'd3);
      check_val("t3_req_still_high", 32'(upd_req), 32'd1);
      frame(4, 5);
      check_val("t3_second_ack", 32'(ack_count), 32'd4);

      // request on the same cycle blank ends from OPEN: missed window
      for (int i = 0; i < 3; i++) begin
         vert_count = 10'(i + 10);
         tick();
      end
      vert_count = 10'd480;
      tick();
      vert_count = 10'd0;
      issue(8'h81, 26'h000_1234, 2'd1);
      tick();
      check_val("t4_state_scan", 32'(dut.state_q), 32'(SCAN));
      check_val("t4_no_ack", 32'(ack_count), 32'd4);
      frame(4, 5);
      check_val("t4_ack_next", 32'(ack_count), 32'd5);

      // blink toggles at vblank 30 and 60
      do_reset(10'd0);
      for (int f = 1; f <= 60; f++) begin
         frame(4, 5);
         if (f == 29) check_val("blink_29", 32'(blink), 32'd0);
         if (f == 30) check_val("blink_30", 32'(blink), 32'd1);
      end
      check_val("frame_count_60", 32'(frame_count), 32'd60);
      check_val("blink_60", 32'(blink), 32'd0);

      // stale_frames saturation and clear on commit
      do_reset(10'd0);
      for (int f = 0; f < 300; f++) frame(3, 3);
      check_val("stale_sat", 32'(stale_frames), 32'd255);
      check_val("frame_count_300", 32'(frame_count), 32'd44);
      issue(8'h42, 26'h000_0042, 2'd2);
      frame(4, 5);
      check_val("stale_clear", 32'(stale_frames), 32'd0);
      frame(4, 5);
      check_val("stale_one", 32'(stale_frames), 32'd1);

      check_val("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_frame_scheduler.md
Name: vga_frame_scheduler

Overview:
Frame-synchronous update scheduler between the elevator simulation core and the VGA pixel path. It accepts display-state updates (destination, people_data, sim_state) over a req/ack handshake and commits at most one update per frame, only during vertical blanking, so the pixel generator never sees tearing. It also produces frame-rate timing services (frame counter, blink toggle, staleness count) for pixel_gen animation.

Parameters:
V_VISIBLE, 480, first blanking line; vert_count >= V_VISIBLE means blanking
BLINK_FRAMES, 30, frames per blink half-period (1..255)
STALE_MAX, 255, saturation value of stale_frames (<=255)

Ports:
pixel_clk  in  1  pixel clock, all logic on posedge
reset  in  1  asynchronous, active-high
vert_count  in  10  current line from VGA timing counter
upd_req  in  1  update request; level, held until upd_ack
upd_destination  in  8  requested destination bitmap
upd_people_data  in  26  requested people data
upd_sim_state  in  2  requested sim state
upd_ack  out  1  one-cycle pulse: update committed
disp_destination  out  8  committed destination to pixel_gen
disp_people_data  out  26  committed people data to pixel_gen
disp_sim_state  out  2  committed sim state to pixel_gen
vblank_start  out  1  one-cycle pulse on first blanking-line cycle
frame_count  out  8  frames since reset, wraps
blink  out  1  toggles every BLINK_FRAMES frames
stale_frames  out  8  frames since last commit, saturating

Behaviour:
- Reset (async, immediate): all outputs 0; FSM = SCAN; in_blank_q = 1; blink_cnt = 0.
- in_blank = (vert_count >= V_VISIBLE); in_blank_q registers it each cycle.
- vblank_start = in_blank & ~in_blank_q (combinational from register + input). in_blank_q resets to 1, so reset released mid-blank gives no pulse; first pulse is at the next real blank entry.
- FSM states: SCAN, OPEN, COMMIT, DONE.
  - SCAN: vblank_start -> OPEN; otherwise stay.
  - OPEN: ~in_blank -> SCAN (window missed, no commit); else upd_req -> COMMIT; else stay. Blank-exit has priority over a same-cycle upd_req.
  - COMMIT: one cycle. Registers disp_* <= upd_* on the clock edge leaving COMMIT; upd_ack = 1 (Moore output) during COMMIT. -> DONE.
  - DONE: ~in_blank -> SCAN.
- Latency: upd_req seen in OPEN at edge N -> upd_ack high during cycle N+1 -> disp_* new value from edge N+2. Request arriving in SCAN/DONE waits for the next OPEN.
- Requester rules: upd_* stable while upd_req high; upd_req low the cycle after upd_ack. upd_req high in the cycle after ack is treated as a new request (serviced next frame).
- At most one commit per frame; disp_* never change while in_blank = 0.
- frame_count: +1 (mod 256) on vblank_start.
- blink_cnt: +1 on vblank_start; when blink_cnt == BLINK_FRAMES-1 on vblank_start, it goes to 0 and blink toggles.
- stale_frames: 0 on commit (edge leaving COMMIT); otherwise +1 on vblank_start, saturating at STALE_MAX. Commit and vblank_start cannot coincide (COMMIT follows OPEN).
- vert_count jumping straight out of blank (e.g. counter reset) in any state -> SCAN next cycle, no commit.

Decomposition:
- Package vga_pkg: typedef enum logic [1:0] {SCAN, OPEN, COMMIT, DONE} sched_state_t; V_VISIBLE, H_VISIBLE, and porch/sync constants shared with the VGA timing generator; display_state_t packed struct {destination, people_data, sim_state}.
- One sub-module: frame_ticker (vblank edge detect, frame_count, blink, stale_frames saturation). FSM and commit registers stay in the top.

Test Plan:
- Reset mid-blank (vert_count = 500), release, upd_req = 1 -> no ack until vert_count goes 479 -> 480; ack 2 cycles after that edge; disp_* equals requested values.
- upd_req = 1 with upd_destination = 8'hA5 during visible line 100 -> ack withheld; disp_destination stays 0 until the next blank, then 8'hA5 on the cycle after ack.
- Two requests in one blank (second asserted right after the first ack) -> exactly one ack this frame; second ack in the following frame's blank.
- upd_req rises on the same cycle vert_count returns to 0 from OPEN -> no ack; FSM in SCAN; ack next frame.
- 60 frames with BLINK_FRAMES = 30 -> blink toggles at vblank_start 30 and 60; frame_count = 60.
- 300 frames with no request -> stale_frames saturates at 255; one commit -> 0, then 1 after the next vblank_start.
